// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and elaboration-time KMP helpers for the sequence detector
`timescale 1ns/1ps
package seq_det_pkg;

  localparam int S_0_IDX = 0;

  typedef enum logic {
    MODE_RESTART = 1'b0,
    MODE_OVERLAP = 1'b1
  } det_mode_e;

  function automatic int state_width(int w);
    return $clog2(w + 1);
  endfunction

  function automatic int s_match_idx(int w);
    return w;
  endfunction

  // Longest pattern prefix that ends the string (first k pattern bits, then b).
  // With k == w this is the overlap transition out of S_MATCH.
  function automatic int kmp_next(logic [15:0] pat, int w, int k, logic b);
    logic [16:0] s;
    logic        ok;
    int          best;
    s = '0;
    for (int i = 0; i < k; i++) begin
      s[i] = pat[w-1-i];
    end
    s[k] = b;
    best = 0;
    for (int j = 1; j <= w && j <= k + 1; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (pat[w-1-i] != s[k+1-j+i]) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detector_moore_param_if.sv
// rtl/seq_detector_moore_param_if.sv - control/data and status bundle of the sequence detector
`timescale 1ns/1ps
interface seq_detector_moore_param_if #(
  parameter int PATTERN_WIDTH = 4,
  parameter int COUNT_WIDTH   = 8
);
  import seq_det_pkg::*;

  localparam int SW = state_width(PATTERN_WIDTH);

  logic                   i_enable;
  logic                   i_data_in;
  logic                   i_overlap;
  logic                   i_clear;
  logic                   o_data_out;
  logic [SW-1:0]          o_progress;
  logic [COUNT_WIDTH-1:0] o_match_count;

  modport master (
    output i_enable, i_data_in, i_overlap, i_clear,
    input  o_data_out, o_progress, o_match_count
  );

  modport slave (
    input  i_enable, i_data_in, i_overlap, i_clear,
    output o_data_out, o_progress, o_match_count
  );

endinterface

// File: rtl/seq_det_match_counter.sv
// rtl/seq_det_match_counter.sv - saturating match counter with synchronous clear
`timescale 1ns/1ps
module seq_det_match_counter #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_inc,
  output logic [COUNT_WIDTH-1:0] o_count
);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {COUNT_WIDTH{1'b1}})) begin
      o_count <= o_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_detector_moore_param.sv
// rtl/seq_detector_moore_param.sv - parametrised Moore serial pattern detector; match counter under SEQ_DET_MATCH_COUNT_EN
`timescale 1ns/1ps
module seq_detector_moore_param
  import seq_det_pkg::*;
#(
  parameter int                       PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 4'b1010,
  parameter int                       COUNT_WIDTH   = 8
) (
  input logic                         i_clock,
  input logic                         i_reset,
  seq_detector_moore_param_if.slave   bus
);

  localparam int              SW      = state_width(PATTERN_WIDTH);
  localparam logic [SW-1:0]   S_0     = SW'(S_0_IDX);
  localparam logic [SW-1:0]   S_MATCH = SW'(s_match_idx(PATTERN_WIDTH));
  localparam logic [15:0]     PAT16   = 16'(PATTERN);

  logic [SW-1:0] next_tab [PATTERN_WIDTH+1][2];
  logic [SW-1:0] state;
  logic [SW-1:0] next_state;
  logic          data_out;
  det_mode_e     mode;

  // Row W holds the overlap transitions out of S_MATCH.
  for (genvar k = 0; k <= PATTERN_WIDTH; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NXT = kmp_next(PAT16, PATTERN_WIDTH, k, 1'(b));
      assign next_tab[k][b] = SW'(NXT);
    end
  end

  assign mode = det_mode_e'(bus.i_overlap);

  always_comb begin
    next_state = next_tab[state][bus.i_data_in];
    if ((state == S_MATCH) && (mode == MODE_RESTART)) begin
      next_state = next_tab[S_0][bus.i_data_in];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= S_0;
      data_out <= 1'b0;
    end else if (bus.i_clear) begin
      state    <= S_0;
      data_out <= 1'b0;
    end else if (bus.i_enable) begin
      state    <= next_state;
      data_out <= (next_state == S_MATCH);
    end
  end

  assign bus.o_data_out = data_out;
  assign bus.o_progress = state;

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic count_inc;
  assign count_inc = bus.i_enable && (next_state == S_MATCH);

  seq_det_match_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_match_counter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (bus.i_clear),
    .i_inc   (count_inc),
    .o_count (bus.o_match_count)
  );
`else
  assign bus.o_match_count = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/seq_detector_moore_param.md
Name: seq_detector_moore_param

Overview:
- Parametrised Moore-style serial sequence detector; next generation of the team's fixed-pattern Moore detector.
- Detects an arbitrary PATTERN_WIDTH-bit pattern on a 1-bit serial stream, MSB first.
- Runtime-selectable overlapping or non-overlapping mode, input qualifier, synchronous clear and an optional saturating match counter.
- Sits on a serial input line; feeds a match strobe to downstream control logic.

Parameters:
- PATTERN_WIDTH, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1010, pattern to detect; bit PATTERN_WIDTH-1 is received first.
- COUNT_WIDTH, 8, width of o_match_count.

Ports:
- i_clock  input  1  rising-edge clock.
- i_reset  input  1  asynchronous, active-low reset.
- i_enable  input  1  input qualifier; i_data_in is sampled only when high.
- i_data_in  input  1  serial data bit.
- i_overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every enabled cycle.
- i_clear  input  1  synchronous clear of state and counter.
- o_data_out  output  1  Moore match output; high while the FSM is in S_MATCH.
- o_progress  output  $clog2(PATTERN_WIDTH+1)  current state index, 0..PATTERN_WIDTH.
- o_match_count  output  COUNT_WIDTH  number of matches since reset or clear.

Behaviour:
- States: S_0..S_(W-1), where S_k means "k leading pattern bits matched", plus S_MATCH (index W). W = PATTERN_WIDTH.
- Reset (i_reset = 0, asynchronous): state = S_0, o_data_out = 0, o_progress = 0, o_match_count = 0. Release is synchronous to i_clock.
- Priority at each rising edge: i_clear, then i_enable.
  - i_clear = 1: state becomes S_0 and the count becomes 0, regardless of i_enable.
  - i_enable = 0: state and count hold. o_data_out therefore stays high if the FSM is held in S_MATCH.
- Transition from S_k, k < W:
  - Expected bit: PATTERN[W-1-k].
  - Input bit equal to expected bit: go to S_(k+1); S_W is S_MATCH.
  - Otherwise: go to S_j, where j is the length of the longest proper prefix of PATTERN that is a suffix of (matched prefix + input bit). This is the KMP failure transition; it never loses a partial match.
- Transition from S_MATCH:
  - i_overlap = 1: take the failure transition of the full pattern, then consume the input bit as above. Back-to-back matches are possible; for example, pattern 1111 with input 1 stays in S_MATCH.
  - i_overlap = 0: restart. Input bit equal to PATTERN[W-1] goes to S_1; otherwise go to S_0.
- Moore output: o_data_out = (state == S_MATCH). It is registered and depends on state only, never combinationally on i_data_in.
- Latency: o_data_out rises in the cycle immediately after the rising edge that sampled the final pattern bit.
- Counter:
  - Increments by 1 on each enabled edge whose next state is S_MATCH, including S_MATCH to S_MATCH.
  - Saturates at all-ones.
- All transition tables are derived from PATTERN at elaboration time, with no runtime pattern storage.
- Mid-operation reset: asynchronous return to the reset values; any partial match is discarded.

Optional Feature:
- Macro: SEQ_DET_MATCH_COUNT_EN.
- Defined: saturating counter implemented as described above.
- Undefined: counter logic is omitted and o_match_count is tied to 0. FSM and o_data_out behaviour are unchanged.

Decomposition:
- Shared package seq_det_pkg holds:
  - state-index width function (clog2);
  - the S_0 and S_MATCH index constants;
  - a constant function computing the KMP failure value for (PATTERN, W, k, bit).
- Sub-module seq_det_match_counter: saturating counter with clear and increment inputs. It is instantiated only under SEQ_DET_MATCH_COUNT_EN.

Test Plan:
- Hold i_reset = 0 for 100 ns, then release. Drive 1,0,1,0,0,1,0,1 with enable = 1 and overlap = 1 (PATTERN 1010) -> one o_data_out pulse, one cycle after the 4th bit; count = 1; o_progress ends at 3.
- Drive 1,0,1,0,1,0 with overlap = 1 -> pulses after bits 4 and 6; count = 2. Repeat with overlap = 0 -> single pulse after bit 4; count = 1.
- Drive 1,1,0,1,0 -> the mismatch at bit 2 falls back to S_1, not S_0; pulse after bit 5; o_progress sequence 1,1,2,3,4.
- Toggle i_enable low for 3 cycles in mid-pattern (1,0,[hold],1,0) -> match still detected. While held in S_MATCH with enable low, o_data_out stays high and the count does not re-increment.
- Assert i_clear while in S_2 with count = 5 -> next cycle o_progress = 0 and count = 0. Assert i_reset mid-pattern -> immediate reset values with no clock edge.
- With COUNT_WIDTH = 2, produce 5 matches -> count saturates at 3. With SEQ_DET_MATCH_COUNT_EN undefined -> count stays 0 and pulses are identical.
